// File: rtl/unsigned_shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier, one multiplier bit per cycle.
// Optional MUL_EARLY_TERMINATE_EN: finish as soon as no unconsumed multiplier bits remain set.
module unsigned_shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     hi,
  output logic                 busy,
  output logic                 rdy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WIDTH-1:0]    mcand;
  logic [2*WIDTH:0]    prod;
  logic [CW-1:0]       cnt;

  logic [WIDTH-1:0]    lo;
  logic [WIDTH:0]      sum;
  logic [2*WIDTH:0]    iter_prod;
  logic                last_iter;
  logic                early_done;

  assign lo = prod[WIDTH-1:0];

  // prod[2*WIDTH] is 0 between iterations, so the top slice is {0, acc}.
  assign sum       = prod[2*WIDTH:WIDTH] + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign iter_prod = {1'b0, sum, lo[WIDTH-1:1]};
  assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef MUL_EARLY_TERMINATE_EN
  logic [WIDTH-1:0]    rem_mask;
  logic [CW-1:0]       shamt;
  logic [2*WIDTH-1:0]  early_prod;

  // Unconsumed multiplier bits after cnt iterations are lo[WIDTH-1-cnt:0].
  assign rem_mask   = {WIDTH{1'b1}} >> cnt;
  assign early_done = ((lo & rem_mask) == '0);
  assign shamt      = CW'(WIDTH) - cnt;
  assign early_prod = prod[2*WIDTH-1:0] >> shamt;
`else
  assign early_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run) state_nxt = S_CALC;
      S_CALC:  if (early_done || last_iter) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    rdy  = 1'b0;
    case (state)
      S_CALC:  busy = 1'b1;
      S_DONE:  rdy  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            mcand <= multiplicand;
            prod  <= {1'b0, {WIDTH{1'b0}}, multiplier};
            cnt   <= '0;
          end
        end
        S_CALC: begin
`ifdef MUL_EARLY_TERMINATE_EN
          if (early_done) begin
            prod <= {1'b0, early_prod};
          end else begin
            prod <= iter_prod;
            cnt  <= cnt + CW'(1);
          end
`else
          prod <= iter_prod;
          cnt  <= cnt + CW'(1);
`endif
        end
        default: ;
      endcase
    end
  end

  assign product = prod[2*WIDTH-1:0];
  assign hi      = prod[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_unsigned_shift_add_multiplier.sv
// Randomized + directed bench for unsigned_shift_add_multiplier against a cycle-count/arithmetic model.
module tb_unsigned_shift_add_multiplier;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           run;
  logic [W-1:0]   tb_a;
  logic [W-1:0]   tb_b;
  logic [2*W-1:0] product;
  logic [W-1:0]   hi;
  logic           busy;
  logic           rdy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  unsigned_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .multiplicand (tb_a),
    .multiplier   (tb_b),
    .product      (product),
    .hi           (hi),
    .busy         (busy),
    .rdy          (rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycles from acceptance edge to the edge entering the done state.
  function automatic int lat(input logic [W-1:0] bb);
`ifdef MUL_EARLY_TERMINATE_EN
    int msb;
    if (bb == '0) return 1;
    msb = 0;
    for (int i = 0; i < W; i++) if (bb[i]) msb = i;
    return (msb + 2 < W) ? msb + 2 : W;
`else
    return W;
`endif
  endfunction

  // Reference model: a countdown plus plain multiplication.
  int           remain = 0;
  bit           m_done = 1'b0;
  logic [63:0]  m_prod = '0;
  logic [W-1:0] ma, mb;

  always @(posedge clk) begin
    if (rst) begin
      remain = 0;
      m_done = 1'b0;
      m_prod = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (remain > 0) begin
      remain--;
      if (remain == 0) begin
        m_done = 1'b1;
        m_prod = 64'(ma) * 64'(mb);
      end
    end else if (run) begin
      ma     = tb_a;
      mb     = tb_b;
      remain = lat(tb_b);
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("model_busy", 64'(busy), 64'(remain > 0));
      chk("model_rdy", 64'(rdy), 64'(m_done));
      if (remain == 0) begin
        chk("model_product", product, m_prod);
        chk("model_hi", 64'(hi), 64'(m_prod[63:32]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv);
    run  = 1'b1;
    tb_a = av;
    tb_b = bv;
    step();
    run  = 1'b0;
    tb_a = $urandom;
    tb_b = $urandom;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!rdy && n < 200) begin
      step();
      n++;
    end
    if (!rdy) chk("rdy_timeout", 64'(n), 64'(0));
  endtask

  initial begin
    int n;
    int pulses;
    logic [W-1:0] ra, rb;

    rst  = 1'b1;
    run  = 1'b0;
    tb_a = '0;
    tb_b = '0;
    repeat (3) step();
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("reset_product", product, 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_rdy", 64'(rdy), 64'h0);

    // 3 * 5
    start(32'd3, 32'd5);
    wait_rdy(n);
    chk("t1_latency", 64'(n), 64'(lat(32'd5)));
    chk("t1_product", product, 64'h0F);
    chk("t1_hi", 64'(hi), 64'h0);
    step();
    chk("t1_busy_after", 64'(busy), 64'h0);
    chk("t1_rdy_after", 64'(rdy), 64'h0);
    chk("t1_product_held", product, 64'h0F);

    // full-range carry path
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rdy(n);
    chk("t2_product", product, 64'hFFFF_FFFE_0000_0001);
    chk("t2_hi", 64'(hi), 64'hFFFF_FFFE);
    step();

    // second run mid-calculation is ignored
    start(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) step();
    run  = 1'b1;
    tb_a = 32'd1;
    tb_b = 32'd1;
    step();
    run  = 1'b0;
    wait_rdy(n);
    chk("t3_latency", 64'(n), 64'(lat(32'h9ABC_DEF0) - 10));
    chk("t3_product", product, 64'h0B00_EA4E_242D_2080);
    step();

    // reset aborts a calculation
    start(32'd7, 32'd9);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_product", product, 64'h0);
    chk("t4_busy", 64'(busy), 64'h0);
    pulses = 0;
    for (int i = 0; i < W + 5; i++) begin
      if (rdy) pulses++;
      step();
    end
    chk("t4_no_rdy", 64'(pulses), 64'h0);
    start(32'd7, 32'd9);
    wait_rdy(n);
    chk("t4_product2", product, 64'h3F);
    step();

    // back-to-back issue in first idle cycle after rdy
    start(32'd2, 32'd3);
    wait_rdy(n);
    chk("t5_product1", product, 64'd6);
    step();
    start(32'd4, 32'd5);
    wait_rdy(n);
    chk("t5_latency2", 64'(n), 64'(lat(32'd5)));
    chk("t5_product2", product, 64'd20);
    step();

    // zero and sparse multipliers
    start(32'd7, 32'd0);
    wait_rdy(n);
    chk("t6_latency_zero", 64'(n), 64'(lat(32'd0)));
    chk("t6_product_zero", product, 64'd0);
    step();
    start(32'd7, 32'd4);
    wait_rdy(n);
    chk("t6_latency_four", 64'(n), 64'(lat(32'd4)));
    chk("t6_product_four", product, 64'd28);
    step();

    // randomized operands, gaps and spurious run pulses
    for (int it = 0; it < 40; it++) begin
      ra = $urandom;
      rb = $urandom;
      if (it % 3 == 1) rb = rb >> $urandom_range(0, W - 1);
      start(ra, rb);
      if ($urandom_range(0, 1) == 1 && busy) begin
        run = 1'b1;
        step();
        run = 1'b0;
      end
      wait_rdy(n);
      chk("rand_product", product, 64'(ra) * 64'(rb));
      if ($urandom_range(0, 1) == 1) run = 1'b1;
      step();
      run = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      if (busy) begin
        wait_rdy(n);
        step();
      end
    end

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
